// File: rtl/ram_rr_arb4_pkg.sv
// Shared types for the four-requester context-RAM arbiter.
// Requester ids and the read-tracking tag record.
package ram_rr_arb4_pkg;

    localparam int NREQ      = 4;
    localparam int RDLAT_DEF = 2;

    typedef logic [1:0] rid_t;

    typedef struct packed {
        logic valid;
        rid_t id;
    } tag_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker.
// Search begins one past the last-served requester and wraps.
module rr_pick4
    import ram_rr_arb4_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  rid_t            ptr,
    output logic [NREQ-1:0] gnt,
    output rid_t            gid,
    output logic            any
);

    rid_t cand;

    always_comb begin
        gid  = ptr;
        any  = 1'b0;
        cand = ptr;
        // k = NREQ wraps back to ptr itself, giving it lowest priority
        for (int k = 1; k <= NREQ; k++) begin
            cand = ptr + rid_t'(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                gid = cand;
            end
        end
        gnt = '0;
        if (any) gnt[gid] = 1'b1;
    end

endmodule

// File: rtl/ram_rr_arb4.sv
// Round-robin arbiter sharing one port of a pipelined context RAM.
// Registers one command per cycle and routes read data back by tag.
module ram_rr_arb4
    import ram_rr_arb4_pkg::*;
#(
    parameter int ADDRBIT = 6,
    parameter int WIDTH   = 80,
    parameter int RDLAT   = RDLAT_DEF
) (
    input  logic                    clk,
    input  logic                    rst_,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         we,
    input  logic [NREQ*ADDRBIT-1:0] addr,
    input  logic [NREQ*WIDTH-1:0]   wdat,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         rvld,
    output logic [WIDTH-1:0]        rdat,
    output logic [ADDRBIT-1:0]      ram_a,
    output logic                    ram_we,
    output logic [WIDTH-1:0]        ram_di,
    input  logic [WIDTH-1:0]        ram_do
);

    rid_t ptr;
    rid_t gid;
    logic any;
    tag_t pipe [RDLAT+1];

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (gnt),
        .gid (gid),
        .any (any)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ptr    <= 2'd3;
            ram_a  <= '0;
            ram_we <= 1'b0;
            ram_di <= '0;
            for (int s = 0; s <= RDLAT; s++) pipe[s] <= '0;
        end else begin
            if (any) begin
                ptr    <= gid;
                ram_a  <= addr[int'(gid)*ADDRBIT +: ADDRBIT];
                ram_we <= we[gid];
                ram_di <= wdat[int'(gid)*WIDTH +: WIDTH];
            end else begin
                ram_we <= 1'b0;
            end
            // Tag travels alongside the RAM latency plus the command register
            pipe[0] <= tag_t'{valid: any & ~we[gid], id: gid};
            for (int s = 1; s <= RDLAT; s++) pipe[s] <= pipe[s-1];
        end
    end

    always_comb begin
        rvld = '0;
        if (pipe[RDLAT].valid) rvld[pipe[RDLAT].id] = 1'b1;
    end

    assign rdat = ram_do;

endmodule

// File: tb/tb_ram_rr_arb4.sv
// Randomized bench for ram_rr_arb4 against a queue-based reference model.
// A second instance with RDLAT = 1 checks grant and return timing.
module tb_ram_rr_arb4;

    import ram_rr_arb4_pkg::*;

    localparam int AB = 6;
    localparam int W  = 80;
    localparam int DL = 2;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]    req, we;
    logic [AB-1:0] a_r [4];
    logic [W-1:0]  d_r [4];
    logic [4*AB-1:0] addr;
    logic [4*W-1:0]  wdat;

    logic [3:0]    gnt, rvld;
    logic [W-1:0]  rdat, ram_di, ram_do;
    logic [AB-1:0] ram_a;
    logic          ram_we;

    logic [3:0]    req2, gnt2, rvld2;
    logic [W-1:0]  rdat2, ram_di2;
    logic [AB-1:0] ram_a2;
    logic          ram_we2;

    always_comb begin
        addr = '0;
        wdat = '0;
        for (int i = 0; i < 4; i++) begin
            addr[i*AB +: AB] = a_r[i];
            wdat[i*W +: W]   = d_r[i];
        end
    end

    ram_rr_arb4 #(.ADDRBIT(AB), .WIDTH(W), .RDLAT(DL)) u_dut (
        .clk(clk), .rst_(rst_), .req(req), .we(we),
        .addr(addr), .wdat(wdat), .gnt(gnt), .rvld(rvld),
        .rdat(rdat), .ram_a(ram_a), .ram_we(ram_we),
        .ram_di(ram_di), .ram_do(ram_do)
    );

    ram_rr_arb4 #(.ADDRBIT(AB), .WIDTH(W), .RDLAT(1)) u_dut1 (
        .clk(clk), .rst_(rst_), .req(req2), .we(4'b0000),
        .addr('0), .wdat('0), .gnt(gnt2), .rvld(rvld2),
        .rdat(rdat2), .ram_a(ram_a2), .ram_we(ram_we2),
        .ram_di(ram_di2), .ram_do('0)
    );

    // RAM: unwritten locations read back their own address
    logic [W-1:0] mem [64];
    bit   [63:0]  wmask;
    logic [W-1:0] rp [DL];

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_a]   <= ram_di;
            wmask[ram_a] <= 1'b1;
        end
        rp[0] <= wmask[ram_a] ? mem[ram_a] : W'(ram_a);
        for (int k = 1; k < DL; k++) rp[k] <= rp[k-1];
    end
    assign ram_do = rp[DL-1];

    int total = 0;
    int bad   = 0;

    task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model
    typedef struct {
        int          due;
        int          id;
        logic [W-1:0] d;
    } ret_t;

    ret_t         rq [$];
    int           rq2 [$];
    logic [W-1:0] mmem [64];
    bit   [63:0]  mmask;
    int           cyc = 0;
    int           mptr = 3;
    int           mptr2 = 3;
    logic         exp_we = 1'b0;
    logic [AB-1:0] exp_a = '0;
    logic [W-1:0] exp_di = '0;
    logic [3:0]   gseen = '0;

    function automatic logic [3:0] pick(logic [3:0] r, int p);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (p + k) % 4;
            if (r[c]) return 4'(1 << c);
        end
        return 4'b0000;
    endfunction

    function automatic logic [W-1:0] rd_model(logic [AB-1:0] a);
        return mmask[a] ? mmem[a] : W'(a);
    endfunction

    always @(negedge clk) begin
        logic [3:0] eg, erv;
        int g;
        cyc++;
        if (!rst_) begin
            mptr = 3;
            mptr2 = 3;
            rq.delete();
            rq2.delete();
            exp_we = 1'b0;
            exp_a = '0;
            gseen = '0;
            chk("rst_rvld", W'(rvld), '0);
            chk("rst_we", W'(ram_we), '0);
            chk("rst_a", W'(ram_a), '0);
            chk("rst_rvld2", W'(rvld2), '0);
        end else begin
            eg = pick(req, mptr);
            chk("gnt", W'(gnt), W'(eg));
            chk("ram_we", W'(ram_we), W'(exp_we));
            chk("ram_a", W'(ram_a), W'(exp_a));
            if (exp_we) chk("ram_di", ram_di, exp_di);
            erv = '0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                erv = 4'(1 << rq[0].id);
                chk("rdat", rdat, rq[0].d);
                void'(rq.pop_front());
            end
            chk("rvld", W'(rvld), W'(erv));
            gseen = gnt;
            exp_we = 1'b0;
            if (eg != 0) begin
                g = $clog2(eg);
                mptr = g;
                exp_a = a_r[g];
                exp_we = we[g];
                exp_di = d_r[g];
                if (we[g]) begin
                    mmem[a_r[g]] = d_r[g];
                    mmask[a_r[g]] = 1'b1;
                end else begin
                    rq.push_back(ret_t'{cyc + DL + 1, g, rd_model(a_r[g])});
                end
            end

            eg = pick(req2, mptr2);
            chk("gnt2", W'(gnt2), W'(eg));
            erv = '0;
            if (rq2.size() > 0 && rq2[0] / 4 == cyc) begin
                erv = 4'(1 << (rq2[0] % 4));
                void'(rq2.pop_front());
            end
            chk("rvld2", W'(rvld2), W'(erv));
            if (eg != 0) begin
                g = $clog2(eg);
                mptr2 = g;
                rq2.push_back((cyc + 2) * 4 + g);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_op(int i);
        req[i] = 1'b1;
        we[i]  = 1'($urandom_range(1));
        a_r[i] = AB'($urandom_range(7));
        d_r[i] = W'({$urandom, $urandom, $urandom});
    endtask

    initial begin
        req = '0;
        we = '0;
        req2 = '0;
        for (int i = 0; i < 4; i++) begin
            a_r[i] = '0;
            d_r[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_ = 1'b1;
        repeat (20) step();

        // all four reading, strict rotation
        for (int i = 0; i < 4; i++) a_r[i] = AB'(10 + i);
        req = 4'b1111;
        repeat (8) step();
        req = '0;
        repeat (5) step();

        // write then read-after-write on the same address
        req = 4'b0100; we = 4'b0100;
        a_r[2] = 6'd5; d_r[2] = W'(16'hABCD);
        step();
        req = 4'b0001; we = '0; a_r[0] = 6'd5;
        step();
        req = '0;
        repeat (5) step();

        // requester 3 must win over 1 right after 1 was served
        req = 4'b0010; a_r[1] = 6'd7;
        step();
        req = 4'b1010; a_r[3] = 6'd9;
        repeat (2) step();
        req = '0;
        repeat (4) step();

        // reset while two reads are in flight
        req = 4'b0011;
        repeat (2) step();
        req = '0; rst_ = 1'b0;
        repeat (2) step();
        rst_ = 1'b1;
        repeat (5) step();
        req = 4'b1000; we = '0; a_r[3] = 6'd12;
        step();
        req = '0;
        repeat (5) step();

        // randomized traffic
        repeat (400) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i] && gseen[i]) begin
                    if ($urandom_range(1) == 1) new_op(i);
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(9) < 4) begin
                    new_op(i);
                end
            end
            req2 = 4'($urandom);
            step();
        end
        req = '0;
        req2 = '0;
        repeat (6) step();
        chk("drain", W'(rq.size()), '0);
        chk("drain2", W'(rq2.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_rr_arb4.md
Name: ram_rr_arb4

Overview:
- Four-requester round-robin arbiter that shares one read/write port of a pipelined-output dual-port RAM (2-cycle read latency: RAM array plus output register).
- Issues one registered RAM command per cycle.
- Tracks in-flight reads and returns read data to the originating requester with a one-hot valid.
- Sits between the E1/STM1 mapper engines and the shared per-channel context RAM.

Parameters:
- ADDRBIT, 6, RAM address width.
- WIDTH, 80, RAM data width.
- RDLAT, 2, cycles from RAM address/we presented to ram_do valid. Must be >= 1.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_  input  1  asynchronous active-low reset.
- req  input  4  per-requester request; held high until granted.
- we  input  4  per-requester op: 1 = write, 0 = read. Sampled with req.
- addr  input  4*ADDRBIT  flat addresses; requester i in bits [i*ADDRBIT +: ADDRBIT].
- wdat  input  4*WIDTH  flat write data; requester i in bits [i*WIDTH +: WIDTH].
- gnt  output  4  one-hot combinational grant, same cycle as the winning req.
- rvld  output  4  one-hot read-data-valid to the originating requester.
- rdat  output  WIDTH  read data, qualified by rvld.
- ram_a  output  ADDRBIT  registered RAM address.
- ram_we  output  1  registered RAM write enable.
- ram_di  output  WIDTH  registered RAM write data.
- ram_do  input  WIDTH  RAM pipelined read data.

Behaviour:
- Clock and reset: one clock (clk); reset rst_ is asynchronous, active-low.
- Reset values:
  - ptr = 3, so requester 0 has first priority.
  - ram_a = 0, ram_we = 0, ram_di = 0.
  - Whole read-tracking pipe cleared: rvld = 0.
  - rdat is a direct pass-through of ram_do (not reset).
- Arbitration, cycle t:
  - Search req starting at (ptr+1) mod 4, wrapping; the first set bit wins.
  - gnt is that one-hot, or 0 if req = 0. gnt never has more than one bit set.
  - gnt depends only on req and ptr, not on we/addr.
- Pointer: on any grant of i, ptr <= i at the edge ending cycle t. With no grant, ptr holds.
  - Consequence: a continuously requesting set is served in strict rotation. Max wait is 3 cycles with 4 requesters.
- Command register, edge ending cycle t:
  - If a grant occurred: ram_a <= addr[i], ram_we <= we[i], ram_di <= wdat[i].
  - If no grant: ram_we <= 0; ram_a and ram_di hold their values.
  - The RAM sees the command in cycle t+1.
- Requester rule:
  - Keep req, we, addr and wdat stable until the cycle gnt[i] is seen.
  - May deassert req in cycle t+1, or keep it high to queue another op. The new op competes under the updated ptr.
- Read tracking: a tag pipe of depth RDLAT+1 carries {valid = grant & ~we[i], id = i}.
  - rvld[id] = 1 exactly RDLAT+1 cycles after the grant cycle. Default RDLAT = 2, so rvld rises at t+3.
  - Writes never produce rvld.
  - Reads are returned in grant order. Back-to-back reads give rvld every cycle with no bubbles.
- Throughput: 1 op/cycle sustained; no stalls; no backpressure on rvld (requesters must accept).
- Simultaneous events: a write and a read to the same address in consecutive grants are serialized in order. A read issued the cycle after a write returns the new data (RAM is write-before-read at the port level).
- Reset mid-operation: in-flight tags are dropped and no rvld is produced for them. ptr returns to 3.
- Address range: addresses >= DEPTH are passed through unchecked.

Decomposition:
- Shared package holds:
  - NREQ = 4.
  - Default RDLAT = 2.
  - Requester-id type, 2 bits.
  - Tag record {valid, id}.
- One sub-module: rr_pick4, the purely combinational 4-way round-robin picker (inputs req, ptr; outputs gnt one-hot, gid 2-bit, any).
- The command register, ptr and tag pipe stay in ram_rr_arb4.

Test Plan:
- Reset released with req = 0: gnt = 0, ram_we = 0, rvld = 0 for 20 cycles; ram_a = 0.
- req = 4'b1111 held, all reads, addr[i] = 10+i, RAM preloaded with data[a] = a:
  - gnt sequence is 1, 2, 4, 8, 1, …
  - rvld follows the same sequence 3 cycles later with rdat = 10, 11, 12, 13.
- Requester 2 writes addr 5 with 0xABCD; next cycle requester 0 reads addr 5:
  - ram_we = 1 then 0 on consecutive cycles.
  - rvld = 4'b0001 at grant+3 with rdat = 0xABCD.
  - No rvld for the write.
- req = 4'b1010 with ptr = 1 after requester 1 is served: gnt = 4'b1000, then 4'b0010. Requester 3 is not starved.
- rst_ pulsed low the cycle after two read grants: no rvld ever appears for them. After release, a single req[3] read gets gnt = 4'b1000 and rvld = 4'b1000 at +3.
- Parameter run with RDLAT = 1, a read grant at cycle t: rvld at t+2, no extra or missing pulse.
